// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DW_DEF    = 140;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned GID_W_DEF = $clog2(N_REQ_DEF);

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester, FIFO write and status signals of the write-port arbiter.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  localparam int unsigned GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_full;
  logic                fifo_w_enable;
  logic [DW-1:0]       data_to_fifo;
  logic [GID_W-1:0]    grant_id;
  logic                busy;
  logic [CNT_W-1:0]    stall_cnt;

  // Arbiter side
  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_w_enable, data_to_fifo, grant_id, busy, stall_cnt
  );

  // Producer / FIFO side
  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_w_enable, data_to_fifo, grant_id, busy, stall_cnt
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin winner search: rotate requests to start at ptr, take lowest set bit, un-rotate.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             found,
  output logic [GID_W-1:0] winner
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [GID_W-1:0]   off;
  logic [GID_W:0]     sum;

  always_comb begin
    dbl   = {req, req};
    rot   = dbl[ptr +: N_REQ];
    found = 1'b0;
    off   = '0;
    // Descending scan so the lowest set bit is the last one written
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = GID_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (GID_W+1)'(N_REQ)) begin
      sum = sum - (GID_W+1)'(N_REQ);
    end
    winner = sum[GID_W-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-level round-robin arbiter driving the async FIFO write port from N_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst,
  fifo_write_arbiter_if.master bus
);

  localparam int unsigned     GID_W     = $clog2(N_REQ);
  localparam logic [GID_W-1:0] LAST_ID  = GID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  arb_state_e       state, state_n;
  logic [GID_W-1:0] grant, grant_n;
  logic [GID_W-1:0] rr_ptr, rr_ptr_n;
  logic [GID_W-1:0] pick;
  logic             found;
  logic [CNT_W-1:0] stall_cnt;
  logic [N_REQ-1:0] ready;
  logic             wen;
  logic [DW-1:0]    wdata;
  logic             stall_hit;

  rr_picker #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_picker (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .found  (found),
    .winner (pick)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  // Arbitration in IDLE; beat gating and packet-end detection in LOCKED
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_ptr_n = rr_ptr;
    ready    = '0;
    wen      = 1'b0;
    wdata    = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        ready[grant] = !bus.fifo_full;
        wen          = bus.req_valid[grant] & !bus.fifo_full;
        if (wen) begin
          wdata = bus.req_data[32'(grant) * DW +: DW];
        end
        if (wen && bus.req_last[grant]) begin
          state_n  = IDLE;
          rr_ptr_n = (grant == LAST_ID) ? '0 : grant + GID_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall_hit = (state == LOCKED) & bus.req_valid[grant] & bus.fifo_full;

  // Saturating back-pressure counter, cleared only by reset
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_hit && stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_w_enable = wen;
  assign bus.data_to_fifo  = wdata;
  assign bus.grant_id      = grant;
  assign bus.busy          = (state == LOCKED);
  assign bus.stall_cnt     = stall_cnt;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle behavioural model plus literal packet/grant checks.
module tb_fifo_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 140;
  localparam int STALL_MAX   = (1 << 16) - 1;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            gap;
  } beat_t;

  logic clk_in;
  logic rst;

  fifo_write_arbiter_if #(.N_REQ(N), .DW(DW), .CNT_W(16)) bus ();
  fifo_write_arbiter_if #(.N_REQ(N), .DW(DW), .CNT_W(4))  bus2 ();

  fifo_write_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(16)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  fifo_write_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(4)) dut_sat (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus2)
  );

  int n_err = 0;
  int n_chk = 0;

  beat_t         pq[N][$];
  bit   [N-1:0]  acc;
  int            flush_gen = 0;
  logic [DW-1:0] wr_q[$];
  int            grant_q[$];

  // Model state
  bit m_locked;
  int m_owner, m_ptr, m_stall;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat sources: present queued beats, honour per-beat idle gaps, pop on acceptance
  initial begin
    bit   [N-1:0]    v, l;
    logic [N*DW-1:0] d;
    bit   [N-1:0]    head_new = '1;
    int              gap_left[N];
    int              seen_gen = 0;
    for (int p = 0; p < N; p++) gap_left[p] = 0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (seen_gen != flush_gen) begin
        seen_gen = flush_gen;
        for (int p = 0; p < N; p++) begin
          pq[p].delete();
          head_new[p] = 1'b1;
          gap_left[p] = 0;
        end
      end
      v = '0;
      l = '0;
      d = '0;
      for (int p = 0; p < N; p++) begin
        if (acc[p] && pq[p].size() > 0) begin
          void'(pq[p].pop_front());
          head_new[p] = 1'b1;
        end
        if (pq[p].size() > 0) begin
          if (head_new[p]) begin
            gap_left[p] = pq[p][0].gap;
            head_new[p] = 1'b0;
          end
          if (gap_left[p] > 0) begin
            gap_left[p]--;
          end else begin
            v[p] = 1'b1;
            l[p] = pq[p][0].last;
            d[p*DW +: DW] = pq[p][0].data;
          end
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  // Compare process: expected outputs from the arbitration rules, checked every cycle
  initial begin
    bit   [N-1:0]  e_rdy;
    bit            e_wen, e_busy, prev_busy, picked;
    logic [DW-1:0] e_data;
    int            e_gid, e_stall, j;
    prev_busy = 1'b0;
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0;
    forever begin
      @(negedge clk_in);
      e_rdy = '0; e_wen = 1'b0; e_data = '0;
      if (rst) begin
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0;
      end else if (m_locked) begin
        e_rdy[m_owner] = !bus.fifo_full;
        e_wen = bus.req_valid[m_owner] && !bus.fifo_full;
        if (e_wen) e_data = bus.req_data[m_owner*DW +: DW];
      end
      e_busy  = m_locked;
      e_gid   = m_owner;
      e_stall = m_stall;
      chk("req_ready",     DW'(bus.req_ready),     DW'(e_rdy));
      chk("fifo_w_enable", DW'(bus.fifo_w_enable), DW'(e_wen));
      chk("data_to_fifo",  bus.data_to_fifo,       e_data);
      chk("grant_id",      DW'(bus.grant_id),      DW'(e_gid));
      chk("busy",          DW'(bus.busy),          DW'(e_busy));
      chk("stall_cnt",     DW'(bus.stall_cnt),     DW'(e_stall));
      if (bus.fifo_w_enable) wr_q.push_back(bus.data_to_fifo);
      if (bus.busy && !prev_busy) grant_q.push_back(int'(bus.grant_id));
      prev_busy = bus.busy;
      acc = bus.req_valid & bus.req_ready;
      if (!rst) begin
        if (m_locked) begin
          if (bus.req_valid[m_owner] && bus.fifo_full && m_stall < STALL_MAX) m_stall++;
          if (e_wen && bus.req_last[m_owner]) begin
            m_locked = 1'b0;
            m_ptr = (m_owner + 1) % N;
          end
        end else begin
          picked = 1'b0;
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!picked && bus.req_valid[j]) begin
              picked = 1'b1;
              m_owner = j;
              m_locked = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic send(input int p, input int nbeats, input logic [DW-1:0] base,
                      input int gap_at, input int gap_len);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = base + DW'(i);
      b.last = (i == nbeats - 1);
      b.gap  = (i == gap_at) ? gap_len : 0;
      pq[p].push_back(b);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int  cnt = 0;
    bit  pending = 1'b1;
    while (pending && cnt < budget) begin
      step(1);
      cnt++;
      pending = bus.busy;
      for (int p = 0; p < N; p++) if (pq[p].size() > 0) pending = 1'b1;
    end
    if (pending) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got still pending after %0d cycles expected drained", name, budget);
    end
  endtask

  task automatic wait_wr(input string name, input int n, input int budget);
    int cnt = 0;
    while (wr_q.size() < n && cnt < budget) begin
      step(1);
      cnt++;
    end
    if (wr_q.size() < n) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_gen++;
    step(2);
    rst = 1'b0;
    wr_q.delete();
    grant_q.delete();
  endtask

  task automatic chk_wr(input string name, input logic [DW-1:0] exp[$]);
    chk({name, "_count"}, DW'(wr_q.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < wr_q.size()) chk(name, wr_q[i], exp[i]);
    end
  endtask

  task automatic chk_gr(input string name, input int exp[$]);
    chk({name, "_count"}, DW'(grant_q.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < grant_q.size()) chk(name, DW'(grant_q[i]), DW'(exp[i]));
    end
  endtask

  initial begin
    logic [DW-1:0] ew[$];
    int            eg[$];
    rst            = 1'b0;
    bus.fifo_full  = 1'b0;
    bus2.fifo_full = 1'b0;
    bus2.req_valid = '0;
    bus2.req_last  = '0;
    bus2.req_data  = '0;
    #1 rst = 1'b1;
    step(3);
    chk("rst_grant_id", DW'(bus.grant_id), '0);
    chk("rst_stall",    DW'(bus.stall_cnt), '0);
    chk("rst_wen",      DW'(bus.fifo_w_enable), '0);
    rst = 1'b0;
    step(1);

    // Single-beat packet on port 0
    send(0, 1, DW'(140'hA5A5A5A5), -1, 0);
    wait_done("single", 20);
    ew = '{DW'(140'hA5A5A5A5)};
    eg = '{0};
    chk_wr("single_data", ew);
    chk_gr("single_grant", eg);

    // All four ports with 2-beat packets, port 0 queued twice
    do_reset();
    for (int p = 0; p < N; p++) send(p, 2, DW'(32'h1000 + p * 16), -1, 0);
    send(0, 2, DW'(32'h1040), -1, 0);
    wait_done("rr", 100);
    ew = '{DW'(32'h1000), DW'(32'h1001), DW'(32'h1010), DW'(32'h1011),
           DW'(32'h1020), DW'(32'h1021), DW'(32'h1030), DW'(32'h1031),
           DW'(32'h1040), DW'(32'h1041)};
    eg = '{0, 1, 2, 3, 0};
    chk_wr("rr_data", ew);
    chk_gr("rr_grant", eg);

    // FIFO full for 5 cycles in the middle of a port 2 packet
    do_reset();
    send(2, 3, DW'(32'h2000), -1, 0);
    wait_wr("full", 1, 20);
    bus.fifo_full = 1'b1;
    step(5);
    bus.fifo_full = 1'b0;
    wait_done("full", 40);
    chk("full_stall_cnt", DW'(bus.stall_cnt), DW'(5));
    ew = '{DW'(32'h2000), DW'(32'h2001), DW'(32'h2002)};
    eg = '{2};
    chk_wr("full_data", ew);
    chk_gr("full_grant", eg);

    // Port 1 pauses 3 cycles mid-packet while port 3 waits
    do_reset();
    send(1, 3, DW'(32'h3000), 1, 3);
    step(1);
    send(3, 1, DW'(32'h3300), -1, 0);
    wait_done("pause", 60);
    ew = '{DW'(32'h3000), DW'(32'h3001), DW'(32'h3002), DW'(32'h3300)};
    eg = '{1, 3};
    chk_wr("pause_data", ew);
    chk_gr("pause_grant", eg);

    // Reset after beat 2 of a 4-beat packet, then a fresh packet
    do_reset();
    send(0, 4, DW'(32'h4000), -1, 0);
    wait_wr("midrst", 2, 20);
    rst = 1'b1;
    flush_gen++;
    #1;
    chk("midrst_busy",  DW'(bus.busy), '0);
    chk("midrst_ready", DW'(bus.req_ready), '0);
    chk("midrst_wen",   DW'(bus.fifo_w_enable), '0);
    chk("midrst_data",  bus.data_to_fifo, '0);
    chk("midrst_gid",   DW'(bus.grant_id), '0);
    step(1);
    rst = 1'b0;
    wr_q.delete();
    grant_q.delete();
    send(0, 1, DW'(32'h4400), -1, 0);
    wait_done("midrst", 20);
    ew = '{DW'(32'h4400)};
    eg = '{0};
    chk_wr("midrst_fresh", ew);
    chk_gr("midrst_grant", eg);

    // Saturation of a 4-bit stall counter
    bus2.req_valid = 4'b0001;
    bus2.req_last  = 4'b0001;
    bus2.fifo_full = 1'b1;
    step(6);
    chk("sat_stall_5", DW'(bus2.stall_cnt), DW'(5));
    chk("sat_busy",    DW'(bus2.busy), DW'(1));
    chk("sat_wen",     DW'(bus2.fifo_w_enable), '0);
    step(19);
    chk("sat_stall_15", DW'(bus2.stall_cnt), DW'(15));
    bus2.fifo_full = 1'b0;
    bus2.req_valid = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
